// File: rtl/pipelined_dmem_arbiter_pkg.sv
// pipelined_dmem_arbiter_pkg: shared state encoding and default loader starvation bound
package pipelined_dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CPU_RD, LD_RD} state_t;
  localparam int MAX_CPU_RUN_DEF = 4;
endpackage

// File: rtl/dmem_arb_fairness.sv
// dmem_arb_fairness: counts CPU grants taken while the loader waits and forces the loader in at the bound
module dmem_arb_fairness import pipelined_dmem_arbiter_pkg::*; #(
  parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF,
  localparam int CW = $clog2(MAX_CPU_RUN + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          ld_req,
  input  logic          cpu_grant,
  input  logic          ld_grant,
  output logic          force_ld,
  output logic [CW-1:0] run_cnt
);
  localparam logic [CW-1:0] MAX = CW'(MAX_CPU_RUN);
  assign force_ld = ld_req && run_cnt == MAX;
  // run length of CPU wins against a pending loader, saturating at the bound
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) run_cnt <= '0;
    else if (!ld_req || ld_grant) run_cnt <= '0;
    else if (cpu_grant && run_cnt != MAX) run_cnt <= run_cnt + 1'b1;
endmodule

// File: rtl/pipelined_dmem_arbiter.sv
// pipelined_dmem_arbiter: shares the single-port data RAM between the MEM stage and a loader port
module pipelined_dmem_arbiter import pipelined_dmem_arbiter_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_CPU_RUN + 1);
  state_t state, state_nxt;
  logic force_ld, grant_ld, grant_cpu;
  logic [CW-1:0] run_cnt;
  logic [DATA_W-1:0] cpu_q, ld_q;
  dmem_arb_fairness #(.MAX_CPU_RUN(MAX_CPU_RUN)) u_fair (
    .clock(clock), .resetn(resetn), .ld_req(ld_req), .cpu_grant(grant_cpu),
    .ld_grant(grant_ld), .force_ld(force_ld), .run_cnt(run_cnt)
  );
  // arbitration, RAM muxing and handshakes; reset gates everything so outputs are quiet while held
  always_comb begin
    grant_ld  = resetn && state == IDLE && ld_req && (force_ld || !cpu_req);
    grant_cpu = resetn && state == IDLE && cpu_req && !grant_ld;
    mem_en    = grant_ld || grant_cpu;
    mem_we    = grant_ld ? ld_we : grant_cpu && cpu_we;
    mem_addr  = grant_ld ? ld_addr : grant_cpu ? cpu_addr : '0;
    mem_wdata = grant_ld ? ld_wdata : grant_cpu ? cpu_wdata : '0;
    cpu_stall = resetn && cpu_req && !(grant_cpu && cpu_we) && state != CPU_RD;
    ld_ack    = (grant_ld && ld_we) || state == LD_RD;
    cpu_rdata = state == CPU_RD ? mem_rdata : cpu_q;
    ld_rdata  = state == LD_RD ? mem_rdata : ld_q;
    state_nxt = mem_en && !mem_we ? (grant_ld ? LD_RD : CPU_RD) : IDLE;
  end
  // state register plus held copies of the last read data per requester
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cpu_q <= '0;
      ld_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == CPU_RD) cpu_q <= mem_rdata;
      if (state == LD_RD) ld_q <= mem_rdata;
    end
endmodule

// File: tb/tb_pipelined_dmem_arbiter.sv
// tb_pipelined_dmem_arbiter: directed self-checking bench with a synchronous-read RAM model
module tb_pipelined_dmem_arbiter;
  logic clock = 0, resetn;
  logic cpu_req, cpu_we, ld_req, ld_we, cpu_stall, ld_ack, mem_en, mem_we;
  logic [7:0] cpu_addr, ld_addr, mem_addr;
  logic [31:0] cpu_wdata, ld_wdata, cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic [31:0] ram [256];
  int checks = 0, errors = 0;
  pipelined_dmem_arbiter dut (
    .clock(clock), .resetn(resetn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ld_req(ld_req),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  // RAM model: write in issue cycle, read data available the following cycle
  always @(posedge clock) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    mem_rdata = 0;
    resetn = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
    ld_req = 1; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    #2;
    chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0); chk("rst_stall", cpu_stall, 0);
    chk("rst_ack", ld_ack, 0); chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_ld_rdata", ld_rdata, 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    tick; tick;
    resetn = 1;
    #2;
    chk("st_en", mem_en, 1); chk("st_we", mem_we, 1); chk("st_addr", mem_addr, 8'h10);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF); chk("st_stall", cpu_stall, 0); chk("st_ack", ld_ack, 0);
    tick;
    cpu_req = 0; ld_req = 0;
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #2;
    chk("ldc_en", mem_en, 1); chk("ldc_we", mem_we, 0); chk("ldc_stall_issue", cpu_stall, 1);
    tick;
    #2;
    chk("ldc_stall_data", cpu_stall, 0); chk("ldc_rdata", cpu_rdata, 32'hDEADBEEF); chk("ldc_no_issue", mem_en, 0);
    tick;
    cpu_req = 0;
    #2;
    chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    tick;
    ld_req = 1; ld_we = 1; ld_addr = 8'h20; ld_wdata = 32'h12345678;
    #2;
    chk("lw_en", mem_en, 1); chk("lw_we", mem_we, 1); chk("lw_addr", mem_addr, 8'h20); chk("lw_ack", ld_ack, 1);
    tick;
    ld_req = 0;
    tick;
    ld_req = 1; ld_we = 0;
    #2;
    chk("lr_issue_ack", ld_ack, 0); chk("lr_en", mem_en, 1); chk("lr_we", mem_we, 0);
    tick;
    #2;
    chk("lr_ack", ld_ack, 1); chk("lr_rdata", ld_rdata, 32'h12345678); chk("lr_no_issue", mem_en, 0);
    tick;
    ld_req = 0;
    tick;
    ld_req = 1; ld_we = 1; ld_addr = 8'h30; ld_wdata = 32'hA5A5A5A5;
    cpu_req = 1; cpu_we = 1; cpu_wdata = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 8'h40 + 8'(i);
      #2;
      chk("run_cpu_addr", mem_addr, 8'h40 + 8'(i)); chk("run_cpu_stall", cpu_stall, 0); chk("run_ack", ld_ack, 0);
      tick;
    end
    cpu_addr = 8'h44;
    #2;
    chk("force_addr", mem_addr, 8'h30); chk("force_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("force_ack", ld_ack, 1); chk("force_stall", cpu_stall, 1);
    tick;
    ld_req = 0;
    #2;
    chk("run_cnt_clr", 32'(dut.u_fair.run_cnt), 0); chk("retry_addr", mem_addr, 8'h44); chk("retry_stall", cpu_stall, 0);
    tick;
    cpu_req = 0;
    #2;
    chk("ram_30", ram[8'h30], 32'hA5A5A5A5); chk("ram_43", ram[8'h43], 32'h0BADF00D);
    tick;
    ld_req = 1; ld_we = 0; ld_addr = 8'h20;
    tick;
    #1;
    resetn = 0;
    #1;
    chk("rrst_ack", ld_ack, 0); chk("rrst_ld_rdata", ld_rdata, 0); chk("rrst_en", mem_en, 0);
    tick;
    #2;
    chk("rrst_ack_held", ld_ack, 0);
    tick;
    resetn = 1;
    #2;
    chk("retry_en", mem_en, 1); chk("retry_ack_issue", ld_ack, 0); chk("retry_ld_addr", mem_addr, 8'h20);
    tick;
    #2;
    chk("retry_ack", ld_ack, 1); chk("retry_rdata", ld_rdata, 32'h12345678);
    tick;
    ld_req = 0;
    #2;
    chk("idle_ack", ld_ack, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
